// File: rtl/briey_reset_seq.sv
// Reset sequencer for the Briey SoC: waits for PLL lock, holds the core in reset, then monitors lock, reset key and watchdog.
// Optional watchdog is built only when BRIEY_RSTSEQ_WDT_EN is defined.
module briey_reset_seq #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic       io_axiClk,
  input  logic       io_reset,
  input  logic       io_pllLock,
  input  logic       io_keyResetN,
  input  logic       io_keyIrqN,
  input  logic       io_wdtKick,
  output logic       io_coreReset,
  output logic       io_coreInterrupt,
  output logic [1:0] io_resetCause,
  output logic [1:0] io_state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10
  } state_t;

  state_t state;
  logic lock_s1, lock_s2;
  // bit 0: reset key, bit 1: interrupt key; both active-low, released = 1
  logic [1:0] key_s1, key_s2;
  logic [1:0] key_deb;
  logic [HOLD_W-1:0] hold_cnt;
  logic key_pressed, irq_level, wdt_expire;

  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      key_s1  <= 2'b11;
      key_s2  <= 2'b11;
    end else begin
      lock_s1 <= io_pllLock;
      lock_s2 <= lock_s1;
      key_s1  <= {io_keyIrqN, io_keyResetN};
      key_s2  <= key_s1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic deb;

    always_ff @(posedge io_axiClk) begin
      if (io_reset) begin
        cnt <= '0;
        deb <= 1'b1;
      end else if (key_s2[k] == deb) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        deb <= key_s2[k];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_deb[k] = deb;
  end

  assign key_pressed = ~key_deb[0];
  assign irq_level   = ~key_deb[1];

`ifdef BRIEY_RSTSEQ_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

  logic kick_s1, kick_s2, kick_d;
  logic kick_rise;
  logic [WDT_W-1:0] wdt_cnt;

  assign kick_rise  = kick_s2 & ~kick_d;
  assign wdt_expire = (state == RUN) && (wdt_cnt == WDT_MAX);

  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      kick_s1 <= 1'b0;
      kick_s2 <= 1'b0;
      kick_d  <= 1'b0;
      wdt_cnt <= '0;
    end else begin
      kick_s1 <= io_wdtKick;
      kick_s2 <= kick_s1;
      kick_d  <= kick_s2;
      if ((state != RUN) || kick_rise || wdt_expire)
        wdt_cnt <= '0;
      else
        wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_kick;
  assign unused_kick = io_wdtKick;
  assign wdt_expire  = 1'b0;
`endif

  // Outputs are set from the state being entered, so core reset and the
  // interrupt gate change on the same edge as the state.
  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      state            <= WAIT_LOCK;
      hold_cnt         <= '0;
      io_coreReset     <= 1'b1;
      io_coreInterrupt <= 1'b0;
      io_resetCause    <= 2'b00;
    end else begin
      case (state)
        WAIT_LOCK: begin
          io_coreReset     <= 1'b1;
          io_coreInterrupt <= 1'b0;
          hold_cnt         <= '0;
          if (lock_s2) state <= HOLD;
        end
        HOLD: begin
          if (!lock_s2) begin
            state            <= WAIT_LOCK;
            hold_cnt         <= '0;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end else if (key_pressed) begin
            hold_cnt         <= '0;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end else if (hold_cnt == HOLD_MAX) begin
            state            <= RUN;
            hold_cnt         <= '0;
            io_coreReset     <= 1'b0;
            io_coreInterrupt <= irq_level;
          end else begin
            hold_cnt         <= hold_cnt + 1'b1;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end
        end
        RUN: begin
          hold_cnt <= '0;
          if (!lock_s2) begin
            state            <= WAIT_LOCK;
            io_resetCause    <= 2'b11;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end else if (key_pressed) begin
            state            <= HOLD;
            io_resetCause    <= 2'b01;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end else if (wdt_expire) begin
            state            <= HOLD;
            io_resetCause    <= 2'b10;
            io_coreReset     <= 1'b1;
            io_coreInterrupt <= 1'b0;
          end else begin
            io_coreReset     <= 1'b0;
            io_coreInterrupt <= irq_level;
          end
        end
        default: begin
          state            <= WAIT_LOCK;
          hold_cnt         <= '0;
          io_coreReset     <= 1'b1;
          io_coreInterrupt <= 1'b0;
        end
      endcase
    end
  end

  assign io_state = state;

endmodule
